but_pair_feeder: RTL and testbench

Streaming input stage placed directly upstream of the combinational radix-2 butterfly `but`. It accepts a serial sample stream with a valid/ready handshake and buffers the first half of each frame. It then pairs sample k with sample k+HALF and presents each pair on registered `out_a`/`out_b` outputs, ready for the butterfly's `a`/`b` inputs. Frames are 2·HALF samples long and may run back-to-back.

---
 rtl/but_pkg.sv | 13 +
 rtl/but_delay_buf.sv | 26 ++
 rtl/but_pair_feeder.sv | 115 +++++++++++
 tb/tb_but_pair_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/but_pkg.sv
// rtl/but_pkg.sv - shared types and widths for the butterfly input path
package but_pkg;

  // Sample width shared by the feeder and the radix-2 butterfly.
  localparam int BUT_DATA_WIDTH = 8;

  // FILL buffers the first half of a frame, PAIR emits pairs against the second half.
  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } but_feed_state_t;

endpackage

// File: rtl/but_delay_buf.sv
// rtl/but_delay_buf.sv - first-half sample store, sync write, async read, no reset
module but_delay_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Contents are only meaningful after a FILL pass, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/but_pair_feeder.sv
// rtl/but_pair_feeder.sv - pairs sample k with k+HALF for the butterfly; optional BUT_PAIR_FEEDER_FLUSH_EN adds a flush input
module but_pair_feeder
  import but_pkg::*;
#(
  parameter  int DATA_WIDTH = BUT_DATA_WIDTH,
  parameter  int HALF       = 8,
  localparam int ADDR_WIDTH = $clog2(HALF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef BUT_PAIR_FEEDER_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last
);

  // HALF is a power of two, so the counter wraps to 0 on its own after HALF-1.
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(HALF - 1);

  but_feed_state_t         r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_a;
  logic [DATA_WIDTH-1:0]   r_out_b;
  logic [ADDR_WIDTH-1:0]   r_out_idx;
  logic                    r_out_last;

  logic                    w_flush;
  logic                    w_in_ready;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_cnt_last;
  logic                    w_buf_wr;
  logic                    w_pair_load;
  logic [DATA_WIDTH-1:0]   w_rd_data;

`ifdef BUT_PAIR_FEEDER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // FILL always accepts; PAIR accepts only when the single output register can
  // be emptied or overwritten this cycle. Gated by rst_n so nothing is taken in reset.
  assign w_in_ready = rst_n && ((r_state == FILL) || !r_out_valid || out_ready);

  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_buf_wr    = w_in_fire && (r_state == FILL) && !w_flush;
  assign w_pair_load = w_in_fire && (r_state == PAIR);

  // FILL only writes and PAIR only reads, so back-to-back frames never collide.
  but_delay_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buf (
    .clk        (clk),
    .i_wr_en    (w_buf_wr),
    .i_wr_addr  (r_cnt),
    .i_wr_data  (in_data),
    .i_rd_addr  (r_cnt),
    .o_rd_data  (w_rd_data)
  );

  // Frame sequencing and the registered output pair; a load wins over a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_flush) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
        if (w_cnt_last) begin
          r_state <= (r_state == FILL) ? PAIR : FILL;
        end
      end
      if (w_pair_load) begin
        r_out_a     <= w_rd_data;
        r_out_b     <= in_data;
        r_out_idx   <= r_cnt;
        r_out_last  <= w_cnt_last;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_but_pair_feeder.sv
// tb/tb_but_pair_feeder.sv - directed self-checking bench for but_pair_feeder (HALF=4, DATA_WIDTH=8)
module tb_but_pair_feeder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [1:0] out_idx;
  logic       out_last;
`ifdef BUT_PAIR_FEEDER_FLUSH_EN
  logic       flush;
  logic       flush_nxt;
`endif

  int n_checks;
  int n_fail;
  int n_stall;

  logic [31:0] q_exp [$];
  logic [7:0]  q_in  [$];

  but_pair_feeder #(
    .DATA_WIDTH (8),
    .HALF       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef BUT_PAIR_FEEDER_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [1:0] idx, input logic last);
    return {13'd0, a, b, idx, last};
  endfunction

  // One cycle: drive at the falling edge, observe 1 time unit later, edge follows.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy, output logic in_fire);
    logic [31:0] e;
    @(negedge clk);
`ifdef BUT_PAIR_FEEDER_FLUSH_EN
    flush = flush_nxt;
`endif
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
    in_fire = v && in_ready;
    if (v && !in_ready) n_stall++;
    if (out_valid && rdy) begin
      if (q_exp.size() == 0) begin
        check_eq("unexpected_pair", 32'd1, 32'd0);
      end else begin
        e = q_exp.pop_front();
        check_eq("pair", {13'd0, out_a, out_b, out_idx, out_last}, e);
      end
    end
  endtask

  task automatic feed_all(input logic rdy, output int cyc);
    logic f;
    int   guard;
    guard = 0;
    while (q_in.size() > 0 && guard < 100) begin
      step(1'b1, q_in[0], rdy, f);
      if (f) void'(q_in.pop_front());
      guard++;
    end
    cyc = guard;
    if (q_in.size() != 0) begin
      check_eq("feed_timeout", q_in.size(), 0);
      q_in.delete();
    end
  endtask

  task automatic drain(input string tag);
    logic f;
    step(1'b0, 8'h00, 1'b1, f);
    check_eq({tag, "_drain"}, q_exp.size(), 0);
    step(1'b0, 8'h00, 1'b1, f);
    check_eq({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
    q_exp.delete();
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (2) @(negedge clk);
    #1;
    check_eq({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_out_ab"},    {16'd0, out_a, out_b}, 32'd0);
    check_eq({tag, "_idx_last"},  {29'd0, out_idx, out_last}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check_eq({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic f;
    int   cyc;
    n_checks  = 0;
    n_fail    = 0;
    n_stall   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
`ifdef BUT_PAIR_FEEDER_FLUSH_EN
    flush     = 1'b0;
    flush_nxt = 1'b0;
`endif

    // Reset behaviour
    apply_reset("rst");

    // Single frame, continuous out_ready
    for (int i = 1; i <= 8; i++) q_in.push_back(8'(i));
    q_exp.push_back(pk(8'h01, 8'h05, 2'd0, 1'b0));
    q_exp.push_back(pk(8'h02, 8'h06, 2'd1, 1'b0));
    q_exp.push_back(pk(8'h03, 8'h07, 2'd2, 1'b0));
    q_exp.push_back(pk(8'h04, 8'h08, 2'd3, 1'b1));
    feed_all(1'b1, cyc);
    check_eq("stream_cycles", cyc, 8);
    check_eq("stream_pending", q_exp.size(), 1);
    drain("stream");

    // Backpressure from the first pair onward
    q_exp.push_back(pk(8'h01, 8'h05, 2'd0, 1'b0));
    q_exp.push_back(pk(8'h02, 8'h06, 2'd1, 1'b0));
    q_exp.push_back(pk(8'h03, 8'h07, 2'd2, 1'b0));
    q_exp.push_back(pk(8'h04, 8'h08, 2'd3, 1'b1));
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i), 1'b0, f);
      check_eq("bp_accept", {31'd0, f}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h06, 1'b0, f);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_hold", {12'd0, out_valid, out_a, out_b, out_idx, out_last},
               {12'd0, 1'b1, 8'h01, 8'h05, 2'd0, 1'b0});
    end
    step(1'b1, 8'h06, 1'b1, f);
    check_eq("bp_release_accept", {31'd0, f}, 32'd1);
    check_eq("bp_one_xfer", q_exp.size(), 3);
    step(1'b1, 8'h07, 1'b0, f);
    check_eq("bp_next", {12'd0, out_valid, out_a, out_b, out_idx, out_last},
             {12'd0, 1'b1, 8'h02, 8'h06, 2'd1, 1'b0});
    q_in.push_back(8'h07);
    q_in.push_back(8'h08);
    feed_all(1'b1, cyc);
    drain("bp");

    // Back-to-back frames
    n_stall = 0;
    for (int i = 1; i <= 16; i++) q_in.push_back(8'(i));
    q_exp.push_back(pk(8'h01, 8'h05, 2'd0, 1'b0));
    q_exp.push_back(pk(8'h02, 8'h06, 2'd1, 1'b0));
    q_exp.push_back(pk(8'h03, 8'h07, 2'd2, 1'b0));
    q_exp.push_back(pk(8'h04, 8'h08, 2'd3, 1'b1));
    q_exp.push_back(pk(8'h09, 8'h0D, 2'd0, 1'b0));
    q_exp.push_back(pk(8'h0A, 8'h0E, 2'd1, 1'b0));
    q_exp.push_back(pk(8'h0B, 8'h0F, 2'd2, 1'b0));
    q_exp.push_back(pk(8'h0C, 8'h10, 2'd3, 1'b1));
    feed_all(1'b1, cyc);
    check_eq("b2b_cycles", cyc, 16);
    check_eq("b2b_no_stall", n_stall, 0);
    drain("b2b");

    // All-ones / all-zeros pass bit-exact, then reset mid-frame
    q_in.push_back(8'hFF); q_in.push_back(8'h00);
    q_in.push_back(8'hFF); q_in.push_back(8'h00);
    q_in.push_back(8'hFF); q_in.push_back(8'h00);
    q_exp.push_back(pk(8'hFF, 8'hFF, 2'd0, 1'b0));
    q_exp.push_back(pk(8'h00, 8'h00, 2'd1, 1'b0));
    feed_all(1'b1, cyc);
    drain("ones");
    apply_reset("midrst");
    for (int i = 0; i < 8; i++) q_in.push_back(8'(8'h10 + i));
    q_exp.push_back(pk(8'h10, 8'h14, 2'd0, 1'b0));
    q_exp.push_back(pk(8'h11, 8'h15, 2'd1, 1'b0));
    q_exp.push_back(pk(8'h12, 8'h16, 2'd2, 1'b0));
    q_exp.push_back(pk(8'h13, 8'h17, 2'd3, 1'b1));
    feed_all(1'b1, cyc);
    drain("after_rst");

`ifdef BUT_PAIR_FEEDER_FLUSH_EN
    // Flush with a pair pending; the stale pair must never transfer
    for (int i = 1; i <= 6; i++) q_in.push_back(8'(i));
    q_exp.push_back(pk(8'h01, 8'h05, 2'd0, 1'b0));
    feed_all(1'b1, cyc);
    flush_nxt = 1'b1;
    step(1'b1, 8'hAA, 1'b0, f);
    flush_nxt = 1'b0;
    step(1'b0, 8'h00, 1'b1, f);
    check_eq("flush_clr", {31'd0, out_valid}, 32'd0);
    check_eq("flush_q", q_exp.size(), 0);
    for (int i = 0; i < 8; i++) q_in.push_back(8'(8'h20 + i));
    q_exp.push_back(pk(8'h20, 8'h24, 2'd0, 1'b0));
    q_exp.push_back(pk(8'h21, 8'h25, 2'd1, 1'b0));
    q_exp.push_back(pk(8'h22, 8'h26, 2'd2, 1'b0));
    q_exp.push_back(pk(8'h23, 8'h27, 2'd3, 1'b1));
    feed_all(1'b1, cyc);
    drain("flush");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
